// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Push-button input conditioner. For each button it synchronises
//            the raw pin, debounces it on a shared slow sample tick, and emits
//            a debounced level plus single-cycle press, long-press and
//            auto-repeat pulses for use as counter enables downstream.
// Ports    : CLK     in   1     system clock
//            RST     in   1     synchronous reset, active-low
//            BTNIN   in   NBTN  raw asynchronous pins, 1 = pressed
//            BTNLVL  out  NBTN  debounced level (registered)
//            BTNOUT  out  NBTN  1-CLK pulse on debounced press
//            BTNLONG out  NBTN  1-CLK pulse after LONG_SMPL ticks held
//            BTNREP  out  NBTN  1-CLK pulse every REP_SMPL ticks after LONG
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
  parameter int NBTN      = 1,
  parameter int SMPL_DIV  = 1250000,
  parameter int DB_SMPL   = 3,
  parameter int LONG_SMPL = 50,
  parameter int REP_SMPL  = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] BTNIN,
  output logic [NBTN-1:0] BTNLVL,
  output logic [NBTN-1:0] BTNOUT,
  output logic [NBTN-1:0] BTNLONG,
  output logic [NBTN-1:0] BTNREP
);

  localparam int CNT_W  = $clog2(SMPL_DIV);
  localparam int HMAX   = (LONG_SMPL > REP_SMPL) ? LONG_SMPL : REP_SMPL;
  localparam int HCNT_W = $clog2(HMAX);

  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(SMPL_DIV - 1);
  localparam logic [HCNT_W-1:0] C_LONG_LAST = HCNT_W'(LONG_SMPL - 1);
  localparam logic [HCNT_W-1:0] C_REP_LAST  = HCNT_W'(REP_SMPL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_REPT = 2'd2
  } state_t;

  // Two-flop synchroniser for the asynchronous pins
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;

  // Shared free-running prescaler
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick;

  always_comb begin
    tick  = (cnt_q == C_CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= BTNIN;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar b = 0; b < NBTN; b++) begin : g_btn
    logic [DB_SMPL-1:0] hist_q;
    logic [DB_SMPL-1:0] hist_d;
    logic               lvl_q;
    logic               lvl_d;
    state_t             state_q;
    state_t             state_d;
    logic [HCNT_W-1:0]  hcnt_q;
    logic [HCNT_W-1:0]  hcnt_d;
    logic               out_q;
    logic               out_d;
    logic               long_q;
    logic               long_d;
    logic               rep_q;
    logic               rep_d;
    logic               rise;
    logic               fall;

    always_comb begin
      hist_d  = hist_q;
      lvl_d   = lvl_q;
      state_d = state_q;
      hcnt_d  = hcnt_q;
      out_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      rise    = 1'b0;
      fall    = 1'b0;

      // The history is judged including the sample taken on this tick, so
      // the level flips on the same edge that completes the run.
      if (tick) begin
        hist_d = {hist_q[DB_SMPL-2:0], sync2_q[b]};
        rise   = (&hist_d) & ~lvl_q;
        fall   = ~(|hist_d) & lvl_q;
      end

      if (rise) lvl_d = 1'b1;
      if (fall) lvl_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HOLD;
            hcnt_d  = '0;
            out_d   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hcnt_q == C_LONG_LAST) begin
              state_d = ST_REPT;
              hcnt_d  = '0;
              long_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        ST_REPT: begin
          if (tick) begin
            if (hcnt_q == C_REP_LAST) begin
              hcnt_d = '0;
              rep_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end
      endcase

      // A release on the same tick as a LONG/REP event suppresses the pulse.
      if (fall) begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
        out_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
      end
    end

    always_ff @(posedge CLK) begin
      if (!RST) begin
        hist_q  <= '0;
        lvl_q   <= 1'b0;
        state_q <= ST_IDLE;
        hcnt_q  <= '0;
        out_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        hist_q  <= hist_d;
        lvl_q   <= lvl_d;
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        out_q   <= out_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    assign BTNLVL[b]  = lvl_q;
    assign BTNOUT[b]  = out_q;
    assign BTNLONG[b] = long_q;
    assign BTNREP[b]  = rep_q;
  end

endmodule
`default_nettype wire
